// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//   Fetch-stage PC generator for the pipelined Y86-64 core. It holds the fetch
//   PC and predicts the next one from the instruction being fetched:
//   jumps and calls are taken, and ret is served from a return-address stack.
//   Execute or write-back can redirect fetch at any time.
//
//   Optional feature macro: PC_PREDICT_RAS_EN builds the return-address stack.
//   When it is undefined, every ret waits for a redirect, and the RAS outputs
//   are tied low.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               hold the PC; the RAS is not updated
//   icode, valC, valP   decode of the instruction at pc
//   redirect, redirect_pc  pipeline correction (highest priority)
//   pc, pc_valid        registered fetch PC; valid while in RUN
//   ras_pred            combinational: this ret takes its target from the RAS
//   ras_count, ras_ovf  live RAS entries; sticky overwrite-of-oldest flag
module pc_predict_unit #(
  parameter int              ADDR_W    = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'd64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [3:0]                   icode,
  input  logic [ADDR_W-1:0]            valC,
  input  logic [ADDR_W-1:0]            valP,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [ADDR_W-1:0]            pc,
  output logic                         pc_valid,
  output logic                         ras_pred,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, WAIT_RET, HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  // Instruction at pc is acted on this edge (no redirect, no stall, RUN).
  logic              act;
  logic              ras_hit;
  logic [ADDR_W-1:0] ras_top;

  assign act = !redirect && !stall && (state == RUN);

`ifdef PC_PREDICT_RAS_EN
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  // ras_ptr addresses the next free slot; the top entry sits one below it.
  logic [PW-1:0]     ras_ptr;
  logic [CW-1:0]     ras_cnt;
  logic              ras_ovf_q;
  logic              push, pop;

  assign ras_hit = (ras_cnt != '0);
  assign ras_top = ras_mem[ras_ptr - PW'(1)];
  assign push    = act && (icode == 4'h8);
  assign pop     = act && (icode == 4'h9) && ras_hit;

  // Pointer wraps modulo RAS_DEPTH, so a push when full lands on the oldest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      ras_ovf_q <= 1'b0;
    end else if (push) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_cnt == CW'(RAS_DEPTH)) ras_ovf_q <= 1'b1;
      else                           ras_cnt   <= ras_cnt + CW'(1);
    end else if (pop) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  // Contents need no reset; ras_cnt gates every read.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= valP;
  end

  assign ras_count = ras_cnt;
  assign ras_ovf   = ras_ovf_q;
`else
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
`endif

  // State and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // Next state / next PC
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (redirect) begin
      state_nx = RUN;
      pc_nx    = redirect_pc;
    end else if (act) begin
      case (icode)
        4'h0:                   state_nx = HALT;
        4'h7, 4'h8:             pc_nx    = valC;
        4'h9: begin
          if (ras_hit) pc_nx    = ras_top;
          else         state_nx = WAIT_RET;
        end
        4'hC, 4'hD, 4'hE, 4'hF: state_nx = HALT;
        default:                pc_nx    = valP;
      endcase
    end
  end

  // Outputs
  always_comb begin
    pc_valid = (state == RUN);
    ras_pred = act && (icode == 4'h9) && ras_hit;
  end
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised fetch-stage PC generator for the pipelined Y86-64 core; it replaces the single-cycle `pc_update` path. It holds the fetch PC in a register and predicts the next PC from the instruction being fetched. Calls and jumps are predicted taken, and `ret` is predicted from an optional return-address stack (RAS). Execute or write-back can redirect fetch at any time to recover from a misprediction, or to resolve a `ret` that was not predicted.

## Interface
Parameters:
- ADDR_W, 64, width of every PC/address value
- RAS_DEPTH, 8, RAS entries; power of two, at least 2
- RESET_PC, 64'd64, PC loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; no RAS update
- icode  in  4  icode of the instruction at `pc` (from fetch)
- valC  in  ADDR_W  destination/constant of the instruction at `pc`
- valP  in  ADDR_W  fall-through address of the instruction at `pc`
- redirect  in  1  pipeline correction request; highest priority
- redirect_pc  in  ADDR_W  corrected target
- pc  out  ADDR_W  current fetch PC (registered)
- pc_valid  out  1  high when `pc` is a genuine fetch address (state RUN)
- ras_pred  out  1  combinational; high when `icode`==9 and the next PC comes from the RAS
- ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries
- ras_ovf  out  1  sticky; set when a push overwrites the oldest entry

## Operation
- States:
  - RUN: fetching.
  - WAIT_RET: a `ret` was not predicted; waiting for the target.
  - HALT: `halt` or an invalid icode was fetched.
- Priority per edge: redirect > stall > state action.
- redirect, any state:
  - `pc`<=redirect_pc and state<=RUN.
  - RAS unchanged: no repair.
  - Takes effect even while stall=1.
- RUN with stall=1: everything holds.
- RUN with no stall, action by icode:
  - 0 (halt): `pc` holds; ->HALT.
  - 7 (jXX, all fn): `pc`<=valC (predicted taken).
  - 8 (call): `pc`<=valC; push valP onto the RAS.
  - 9 (ret), RAS non-empty: `pc`<=top; pop.
  - 9 (ret), RAS empty: `pc` holds; ->WAIT_RET.
  - 1–6 and A–B: `pc`<=valP.
  - C–F (invalid): ->HALT.
- WAIT_RET and HALT: `pc` holds and `icode` is ignored. Only redirect or reset leaves these states.
- pc_valid = (state==RUN).
- RAS structure:
  - Circular buffer with a top pointer.
  - Push when full overwrites the oldest entry, sets ras_ovf, and leaves ras_count at RAS_DEPTH.
  - Pop decrements ras_count.
- The pipeline compares a RAS-predicted `ret` target against valM in write-back and issues redirect on mismatch. ras_pred tells the pipeline which `ret`s to check.
- Arithmetic: only pointer arithmetic, modulo RAS_DEPTH. No PC addition is done here; valP arrives precomputed.

## Timing
- Reset (asynchronous) values:
  - `pc`=RESET_PC, state=RUN, pc_valid=1.
  - ras_count=0, ras_ovf=0, top pointer=0.
  - RAS contents are don't-care.
- Latency: next PC is visible one cycle after the instruction's icode is presented.
- A redirect is visible on `pc` at the edge after it is sampled.
- redirect on the same edge as `icode`==8: the redirect wins and no push occurs.
- Reset mid-WAIT_RET or mid-HALT returns to RUN at RESET_PC immediately and asynchronously.
- ras_pred is combinational; it is low when stall or redirect is high.

## Configuration
- `PC_PREDICT_RAS_EN` defined:
  - RAS is built as described.
- `PC_PREDICT_RAS_EN` undefined:
  - No RAS storage.
  - Every `ret` in RUN goes to WAIT_RET (classic PIPE bubble behaviour).
  - ras_count=0, ras_ovf=0 and ras_pred=0 at all times.

## Test plan
- Reset then run. Stimulus: reset, then icode=6, valP=66. Response: `pc`=64 during reset, 66 one cycle later, pc_valid=1.
- Call/ret round trip. Stimulus: icode=8 at pc=76 with valC=200, valP=85; then icode=9. Response: `pc`=200, ras_count=1; then `pc`=85, ras_pred=1, ras_count=0. Without the macro, the `ret` gives pc_valid=0 until redirect_pc=85.
- RAS overflow. Stimulus: RAS_DEPTH=8, 9 calls with valP=1..9, then 9 rets. Response: ras_ovf=1; rets return 9,8,…,2; the 9th `ret` enters WAIT_RET.
- Jump misprediction. Stimulus: icode=7 with valC=113; one cycle later redirect=1, redirect_pc=108. Response: `pc`=113, then 108.
- Halt. Stimulus: icode=0 at pc=113. Response: `pc` stays 113, pc_valid=0 for 10 cycles. Then redirect to 70: `pc`=70, pc_valid=1.
- Stall versus redirect. Stimulus: stall=1 and icode=8; then stall=1 and redirect=1 with redirect_pc=90. Response: no change and ras_count unchanged; then `pc`=90.
